// File: rtl/wrr_pkt_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// wrr_pkt_arb : weighted round-robin packet arbiter with grant hold and
//               stall timeout.  Rev 1.0
// ============================================================================
module wrr_pkt_arb #(
  parameter int NUM_REQS = 4,
  parameter int WGT_W    = 4,
  parameter int TO_CYC   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQS-1:0]           req_i,
  input  logic [NUM_REQS-1:0]           req_last_i,
  input  logic [NUM_REQS*WGT_W-1:0]     weight_i,
  input  logic                          ds_ready_i,
  output logic [NUM_REQS-1:0]           gnt_o,
  output logic [$clog2(NUM_REQS)-1:0]   gnt_id_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int ID_W    = $clog2(NUM_REQS);
  localparam int STALL_W = $clog2(TO_CYC);
  localparam logic [STALL_W-1:0] C_STALL_MAX = STALL_W'(TO_CYC - 1);
  localparam logic [ID_W-1:0]    C_LAST_ID   = ID_W'(NUM_REQS - 1);
  localparam logic [ID_W:0]      C_NUM_REQS  = (ID_W+1)'(NUM_REQS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                 state_q;
  logic [NUM_REQS-1:0]    gnt_q;
  logic [ID_W-1:0]        gnt_id_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        last_owner_q;
  logic [WGT_W-1:0]       credit_q;
  logic [STALL_W-1:0]     stall_q;
  logic                   busy_q;
  logic                   timeout_q;

  logic [WGT_W-1:0]       w_wgt [NUM_REQS];
  logic [ID_W-1:0]        w_srch_id;
  logic                   w_keep;
  logic [ID_W-1:0]        w_win;
  logic [NUM_REQS-1:0]    w_win_oh;
  logic                   w_reload;
  logic [WGT_W-1:0]       w_load_val;
  logic [ID_W-1:0]        ptr_d;
  logic                   w_xfer;
  logic                   w_pkt_end;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_wgt
    assign w_wgt[g] = weight_i[g*WGT_W +: WGT_W];
  end

  // Round-robin search: scanning offsets high-to-low leaves the nearest hit
  // at or above ptr_q as the final assignment.
  always_comb begin : p_search
    logic [ID_W:0] sum;
    sum       = '0;
    w_srch_id = ptr_q;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= C_NUM_REQS) begin
        sum = sum - C_NUM_REQS;
      end
      if (req_i[sum[ID_W-1:0]]) begin
        w_srch_id = sum[ID_W-1:0];
      end
    end
  end

  assign w_keep     = req_i[last_owner_q] && (credit_q != '0);
  assign w_win      = w_keep ? last_owner_q : w_srch_id;
  assign w_win_oh   = NUM_REQS'(1) << w_win;
  assign w_reload   = (w_win != last_owner_q) || (credit_q == '0);
  assign w_load_val = (w_wgt[w_win] == '0) ? WGT_W'(1) : w_wgt[w_win];
  assign ptr_d      = (w_win == C_LAST_ID) ? '0 : w_win + 1'b1;

  // gnt_q is one-hot in GRANT, so reducing the masked vectors picks the owner.
  assign w_xfer    = (|(gnt_q & req_i)) & ds_ready_i;
  assign w_pkt_end = (|(gnt_q & req_i & req_last_i)) & ds_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      ptr_q        <= '0;
      last_owner_q <= '0;
      credit_q     <= '0;
      stall_q      <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q      <= GRANT;
            gnt_q        <= w_win_oh;
            gnt_id_q     <= w_win;
            busy_q       <= 1'b1;
            last_owner_q <= w_win;
            ptr_q        <= ptr_d;
            stall_q      <= '0;
            if (w_reload) begin
              credit_q <= w_load_val;
            end
          end
        end
        GRANT: begin
          if (w_pkt_end) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            stall_q  <= '0;
            if (credit_q != '0) begin
              credit_q <= credit_q - 1'b1;
            end
          end else if (w_xfer) begin
            stall_q <= '0;
          end else if (stall_q == C_STALL_MAX) begin
            // Abandoned packet: zero credit so the next decision rotates on.
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            stall_q   <= '0;
            credit_q  <= '0;
            timeout_q <= 1'b1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_timeout_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    timeout_q |=> !timeout_q);
  a_grant_credit : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT) |-> (credit_q != '0));
  a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q == GRANT));

endmodule

`default_nettype wire

// File: tb/tb_wrr_pkt_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_wrr_pkt_arb : scoreboard bench for wrr_pkt_arb with a packet-level
//                  reference model and randomized requesters.  Rev 1.0
// ============================================================================
module tb_wrr_pkt_arb;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int TO  = 6;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_last;
  logic [N*WW-1:0] weight;
  logic            ds_ready;
  logic [N-1:0]    gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout;

  wrr_pkt_arb #(.NUM_REQS(N), .WGT_W(WW), .TO_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .req_last_i (req_last),
    .weight_i   (weight),
    .ds_ready_i (ds_ready),
    .gnt_o      (gnt),
    .gnt_id_o   (gnt_id),
    .busy_o     (busy),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
    logic           to;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           gnt_log[$];
  int           hold_cnt = 0;
  int           to_cnt = 0;
  logic [N-1:0] prev_gnt = '0;

  // Reference model: arbitration rules expressed over integers.
  int m_in, m_owner, m_credit, m_ptr, m_last, m_run;

  // Requester drivers and stimulus knobs.
  bit     d_act [N];
  int     d_left[N];
  int     d_drop[N];
  bit     pend_x[N];
  bit [N-1:0] cfg_mask;
  int     cfg_minlen, cfg_maxlen, cfg_start_pct, cfg_ds_pct, cfg_drop_pct, cfg_drop_len;

  function automatic int wgt(input int i);
    return int'(weight[i*WW +: WW]);
  endfunction

  task automatic model_reset();
    m_in = 0; m_owner = 0; m_credit = 0; m_ptr = 0; m_last = 0; m_run = 0;
  endtask

  task automatic model_step();
    exp_t x;
    bit   to;
    int   win;
    bit   moved;
    to = 1'b0;
    if (m_in == 0) begin
      if (req != '0) begin
        if (req[m_last] && m_credit > 0) begin
          win = m_last;
        end else begin
          win = -1;
          for (int k = 0; k < N; k++)
            if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        if (win != m_last || m_credit == 0) m_credit = (wgt(win) == 0) ? 1 : wgt(win);
        m_last = win; m_owner = win; m_ptr = (win + 1) % N;
        m_in = 1; m_run = 0;
      end
    end else begin
      moved = req[m_owner] && ds_ready;
      if (moved && req_last[m_owner]) begin
        if (m_credit > 0) m_credit--;
        m_in = 0;
      end else if (moved) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == TO) begin
          to = 1'b1; m_credit = 0; m_in = 0;
        end
      end
    end
    x.gnt = '0;
    if (m_in != 0) x.gnt[m_owner] = 1'b1;
    x.id   = (m_in != 0) ? IDW'(m_owner) : '0;
    x.busy = (m_in != 0);
    x.to   = to;
    exp_q.push_back(x);
  endtask

  task automatic drivers_reset();
    for (int i = 0; i < N; i++) begin
      d_act[i] = 1'b0; d_left[i] = 0; d_drop[i] = 0; pend_x[i] = 1'b0;
    end
    req = '0; req_last = '0;
  endtask

  // Called just after a falling edge; returns on the next falling edge.
  task automatic drive_cycle();
    for (int i = 0; i < N; i++) begin
      if (pend_x[i]) begin
        d_left[i]--;
        if (d_left[i] == 0) d_act[i] = 1'b0;
      end
      if (d_drop[i] > 0) d_drop[i]--;
      if (!d_act[i] && cfg_mask[i] && int'($urandom_range(99)) < cfg_start_pct) begin
        d_act[i]  = 1'b1;
        d_left[i] = int'($urandom_range(cfg_maxlen, cfg_minlen));
      end
      if (d_act[i] && gnt[i] && d_drop[i] == 0 && int'($urandom_range(99)) < cfg_drop_pct)
        d_drop[i] = (cfg_drop_len > 0) ? cfg_drop_len : int'($urandom_range(TO + 2, 2));
      req[i]      = d_act[i] && (d_drop[i] == 0);
      req_last[i] = d_act[i] && (d_left[i] == 1);
    end
    if (cfg_ds_pct < 0) ds_ready = ~ds_ready;
    else                ds_ready = int'($urandom_range(99)) < cfg_ds_pct;
    for (int i = 0; i < N; i++) pend_x[i] = gnt[i] && req[i] && ds_ready;
    model_step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({gnt, gnt_id, busy, timeout} !== '0) begin
      n_bad++;
      $display("FAIL %s: gnt=%b id=%0d busy=%b timeout=%b, required all zero",
               name, gnt, gnt_id, busy, timeout);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req_v);
    n_cmp++;
    if (act != req_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req_v);
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    exp_q.delete();
    model_reset();
    drivers_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin : p_monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({gnt, gnt_id, busy, timeout} !== e) begin
        n_bad++;
        $display("FAIL cycle@%0t: gnt=%b id=%0d busy=%b to=%b, required gnt=%b id=%0d busy=%b to=%b",
                 $time, gnt, gnt_id, busy, timeout, e.gnt, e.id, e.busy, e.to);
      end
    end
    if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(int'(gnt_id));
    if (gnt == 4'b0100) hold_cnt++;
    if (timeout === 1'b1) to_cnt++;
    prev_gnt = gnt;
  end

  int seq_a[5] = '{0, 1, 2, 3, 0};
  int seq_b[8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    rst_n = 1'b0; ds_ready = 1'b0; weight = '0;
    model_reset();
    drivers_reset();
    cfg_mask = '0; cfg_minlen = 1; cfg_maxlen = 1; cfg_start_pct = 0;
    cfg_ds_pct = 100; cfg_drop_pct = 0; cfg_drop_len = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Equal weights, all requesting, single-beat packets.
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    cfg_mask = 4'b1111; cfg_start_pct = 100;
    gnt_log.delete();
    repeat (12) drive_cycle();
    for (int i = 0; i < 5; i++)
      check_int($sformatf("rr_order[%0d]", i), (gnt_log.size() > i) ? gnt_log[i] : -1, seq_a[i]);

    // Weighted quota 3:1.
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    cfg_mask = 4'b0011;
    gnt_log.delete();
    repeat (16) drive_cycle();
    for (int i = 0; i < 8; i++)
      check_int($sformatf("wrr_order[%0d]", i), (gnt_log.size() > i) ? gnt_log[i] : -1, seq_b[i]);

    // Grant held through a stalling 4-beat packet.
    do_reset();
    ds_ready = 1'b0;
    cfg_mask = 4'b0100; cfg_minlen = 4; cfg_maxlen = 4; cfg_ds_pct = -1;
    hold_cnt = 0;
    drive_cycle();
    cfg_start_pct = 0;
    repeat (11) drive_cycle();
    check_int("stall_hold_cycles", hold_cnt, 8);
    check_zero("stall_hold_release");

    // Owner 1 abandons its packet; requester 2 takes over after timeout.
    do_reset();
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    cfg_mask = 4'b0110; cfg_start_pct = 100; cfg_ds_pct = 100;
    cfg_drop_pct = 100; cfg_drop_len = TO + 3;
    to_cnt = 0;
    gnt_log.delete();
    repeat (2) drive_cycle();
    cfg_drop_pct = 0; cfg_start_pct = 0;
    repeat (12) drive_cycle();
    check_int("timeout_pulses", to_cnt, 1);
    check_int("timeout_first_owner", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    check_int("timeout_next_owner", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);

    // Randomized traffic, weights including zero, changed mid-flight.
    do_reset();
    cfg_mask = 4'b1111; cfg_minlen = 1; cfg_maxlen = 4; cfg_start_pct = 30;
    cfg_ds_pct = 70; cfg_drop_pct = 3; cfg_drop_len = 0;
    for (int blk = 0; blk < 8; blk++) begin
      weight = 16'($urandom);
      if ($urandom_range(1) == 1) weight[15:12] = 4'd0;
      repeat (250) drive_cycle();
    end

    // Reset landing inside a packet.
    begin
      int k;
      k = 0;
      while (gnt == '0 && k < 50) begin
        drive_cycle();
        k++;
      end
      n_cmp++;
      if (gnt == '0) begin
        n_bad++;
        $display("FAIL wait_for_grant: gnt=%b after %0d cycles, required nonzero", gnt, k);
      end
    end
    do_reset();
    cfg_mask = 4'b1100; cfg_start_pct = 100;
    gnt_log.delete();
    drive_cycle();
    cfg_mask = 4'b1111; cfg_start_pct = 30;
    repeat (500) drive_cycle();
    check_int("post_reset_first_owner", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
